// File: rtl/ctrl_defs.sv
// Shared definitions for the multi-cycle MIPS control unit: ALU commands,
// opcode constants, state encodings and the control-word layout.
package ctrl_defs;

  // ALU commands understood by the ALU control decoder
  localparam logic [2:0] ALUOp_CMD_ADD   = 3'b000;
  localparam logic [2:0] ALUOp_CMD_SUB   = 3'b001;
  localparam logic [2:0] ALUOp_CMD_RTYPE = 3'b010;

  // Supported instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_IF       = 4'd1,
    ST_ID       = 4'd2,
    ST_MEM_ADDR = 4'd3,
    ST_MEM_RD   = 4'd4,
    ST_MEM_WB   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_EX_R     = 4'd7,
    ST_R_WB     = 4'd8,
    ST_EX_I     = 4'd9,
    ST_I_WB     = 4'd10,
    ST_EX_BEQ   = 4'd11,
    ST_EX_J     = 4'd12
  } state_t;

  // Per-state datapath control word (before mem_ready gating)
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] aluop;
  } ctrl_word_t;

  // True for every opcode the datapath can execute
  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_state_decode.sv
// Combinational decoder from the FSM state to the datapath control word.
// Anything not set explicitly for a state is left at zero.
module control_state_decode
  import ctrl_defs::*;
(
  input  state_t     state,
  output ctrl_word_t cw
);

  // One control word per state; INIT and unused encodings produce all zeros
  always_comb begin
    cw = '0;
    case (state)
      ST_IF: begin
        cw.mem_read  = 1'b1;
        cw.alu_src_a = 1'b0;
        cw.alu_src_b = 2'b01;
        cw.aluop     = ALUOp_CMD_ADD;
        cw.ir_write  = 1'b1;
        cw.pc_write  = 1'b1;
      end
      ST_ID: begin
        cw.alu_src_a = 1'b0;
        cw.alu_src_b = 2'b11;
        cw.aluop     = ALUOp_CMD_ADD;
      end
      ST_MEM_ADDR: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
        cw.aluop     = ALUOp_CMD_ADD;
      end
      ST_MEM_RD: begin
        cw.i_or_d   = 1'b1;
        cw.mem_read = 1'b1;
      end
      ST_MEM_WB: begin
        cw.reg_dst    = 1'b0;
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
      end
      ST_MEM_WR: begin
        cw.i_or_d    = 1'b1;
        cw.mem_write = 1'b1;
      end
      ST_EX_R: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b00;
        cw.aluop     = ALUOp_CMD_RTYPE;
      end
      ST_R_WB: begin
        cw.reg_dst    = 1'b1;
        cw.mem_to_reg = 1'b0;
        cw.reg_write  = 1'b1;
      end
      ST_EX_I: begin
        cw.alu_src_a = 1'b1;
        cw.alu_src_b = 2'b10;
        cw.aluop     = ALUOp_CMD_ADD;
      end
      ST_I_WB: begin
        cw.reg_dst    = 1'b0;
        cw.mem_to_reg = 1'b0;
        cw.reg_write  = 1'b1;
      end
      ST_EX_BEQ: begin
        cw.alu_src_a     = 1'b1;
        cw.alu_src_b     = 2'b00;
        cw.aluop         = ALUOp_CMD_SUB;
        cw.pc_write_cond = 1'b1;
        cw.pc_source     = 2'b01;
      end
      ST_EX_J: begin
        cw.pc_write  = 1'b1;
        cw.pc_source = 2'b10;
      end
      default: cw = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath. Holds the state
// register and next-state logic; outputs are decoded from the state, with
// only IF's ir_write/pc_write gated by mem_ready and the ID illegal pulse
// depending on the opcode.
module multicycle_control
  import ctrl_defs::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                illegal,
  output logic [3:0]          state
);

  state_t     state_q;
  ctrl_word_t cw;
  logic [5:0] op;

  assign op = 6'(opcode);

  // State register and next-state selection; reset abandons any instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      case (state_q)
        ST_INIT: state_q <= ST_IF;
        ST_IF:   if (mem_ready) state_q <= ST_ID;
        ST_ID: begin
          case (op)
            OP_LW, OP_SW: state_q <= ST_MEM_ADDR;
            OP_RTYPE:     state_q <= ST_EX_R;
            OP_ADDI:      state_q <= ST_EX_I;
            OP_BEQ:       state_q <= ST_EX_BEQ;
            OP_J:         state_q <= ST_EX_J;
            default:      state_q <= ST_IF;
          endcase
        end
        ST_MEM_ADDR: state_q <= (op == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD:   if (mem_ready) state_q <= ST_MEM_WB;
        ST_MEM_WB:   state_q <= ST_IF;
        ST_MEM_WR:   if (mem_ready) state_q <= ST_IF;
        ST_EX_R:     state_q <= ST_R_WB;
        ST_R_WB:     state_q <= ST_IF;
        ST_EX_I:     state_q <= ST_I_WB;
        ST_I_WB:     state_q <= ST_IF;
        ST_EX_BEQ:   state_q <= ST_IF;
        ST_EX_J:     state_q <= ST_IF;
        default:     state_q <= ST_INIT;
      endcase
    end
  end

  control_state_decode u_decode (
    .state (state_q),
    .cw    (cw)
  );

  // IF only commits the fetch (IR load + PC increment) once memory is ready
  assign ir_write      = cw.ir_write & mem_ready;
  assign pc_write      = cw.pc_write & (mem_ready | (state_q != ST_IF));
  assign pc_write_cond = cw.pc_write_cond;
  assign i_or_d        = cw.i_or_d;
  assign mem_read      = cw.mem_read;
  assign mem_write     = cw.mem_write;
  assign mem_to_reg    = cw.mem_to_reg;
  assign reg_dst       = cw.reg_dst;
  assign reg_write     = cw.reg_write;
  assign alu_src_a     = cw.alu_src_a;
  assign alu_src_b     = cw.alu_src_b;
  assign pc_source     = cw.pc_source;
  assign aluop         = ALUOP_W'(cw.aluop);
  assign illegal       = (state_q == ST_ID) && !op_supported(op);
  assign state         = state_q;

endmodule
